conv_seq_ctrl: RTL and testbench

- Control sequencer for the layer-0 convolution / layer-1 max-pool engine.
- Walks a 64x64 image pixel by pixel and issues 3x3 window input addresses with a zero-padding flag and kernel tap index to an external MAC/ReLU/max datapath.
- Strobes layer-0 writeback, then runs the 2x2 stride-2 max-pool pass over layer-0 memory into layer-1 memory.
- Owns busy/ready, iaddr, all cwr/crd/caddr/csel signals, and every datapath enable.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_seq_ctrl_if.sv | 41 ++++
 rtl/conv_win_addr.sv | 35 +++
 rtl/conv_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the layer-0 convolution / layer-1 max-pool sequencer:
// sequencer states, memory select codes, image geometry and the 3x3 window
// offset table (tap k -> dy = k/3-1, dx = k%3-1).
package conv_pkg;

   localparam int IMG_W  = 64;
   localparam int POOL_W = IMG_W / 2;

   localparam logic [2:0] CSEL_NONE = 3'b000;
   localparam logic [2:0] CSEL_L0   = 3'b001;
   localparam logic [2:0] CSEL_L1   = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WB0,
      S_POOL,
      S_WB1,
      S_DONE
   } state_t;

   localparam int DY_TAB [0:8] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
   localparam int DX_TAB [0:8] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Host/datapath/memory bundle of the convolution sequencer.
//   ready                         host start request (slave -> master)
//   busy                          job in progress
//   iaddr, tap_idx                image read address / kernel tap 0..8
//   mac_clr, mac_en, mac_pad      accumulator controls
//   pool_ld, pool_en, wb_sel      max register controls / write data source
//   cwr, caddr_wr, crd, caddr_rd  memory write/read strobes and addresses
//   csel                          memory select (001 layer-0, 011 layer-1)
interface conv_seq_ctrl_if #(
   parameter int ADDR_W = 12
) ();

   logic              ready;
   logic              busy;
   logic [ADDR_W-1:0] iaddr;
   logic [3:0]        tap_idx;
   logic              mac_clr;
   logic              mac_en;
   logic              mac_pad;
   logic              pool_ld;
   logic              pool_en;
   logic              wb_sel;
   logic              cwr;
   logic [ADDR_W-1:0] caddr_wr;
   logic              crd;
   logic [ADDR_W-1:0] caddr_rd;
   logic [2:0]        csel;

   modport master (
      input  ready,
      output busy, iaddr, tap_idx, mac_clr, mac_en, mac_pad,
             pool_ld, pool_en, wb_sel, cwr, caddr_wr, crd, caddr_rd, csel
   );

   modport slave (
      output ready,
      input  busy, iaddr, tap_idx, mac_clr, mac_en, mac_pad,
             pool_ld, pool_en, wb_sel, cwr, caddr_wr, crd, caddr_rd, csel
   );

endinterface

// File: rtl/conv_win_addr.sv
// 3x3 window address generator (purely combinational).
//   row, col   centre pixel
//   tap        kernel tap 0..8 (values above 8 are treated as tap 0)
//   iaddr      (row+dy)*IMG + (col+dx), or 0 when the tap falls off the image
//   mac_pad    tap lies outside the image; datapath substitutes zero
module conv_win_addr #(
   parameter int ROW_W = 6,
   parameter int AW    = 12
) (
   input  logic [ROW_W-1:0] row,
   input  logic [ROW_W-1:0] col,
   input  logic [3:0]       tap,
   output logic [AW-1:0]    iaddr,
   output logic             mac_pad
);
   import conv_pkg::*;

   localparam int IMG = 1 << ROW_W;

   int kk;
   int rr;
   int cc;

   always_comb begin
      kk      = (tap > 4'd8) ? 0 : int'(tap);
      rr      = int'(row) + DY_TAB[kk];
      cc      = int'(col) + DX_TAB[kk];
      mac_pad = (rr < 0) || (rr >= IMG) || (cc < 0) || (cc >= IMG);
      iaddr   = '0;
      if (!mac_pad) begin
         iaddr = AW'(rr * IMG + cc);
      end
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Control sequencer for the conv (layer-0) / max-pool (layer-1) engine.
// Ports: clk, reset (synchronous, active-high), bus (master side of
// conv_seq_ctrl_if: ready in; busy, iaddr, tap_idx, mac_*, pool_*, wb_sel,
// cwr/caddr_wr, crd/caddr_rd, csel out).
// Per pixel: 9 CONV cycles (taps 0..8) then one WB0 write to layer-0.
// Per pooled output: 4 POOL reads of a 2x2 block then one WB1 write to layer-1.
// All outputs are decoded from registered state and counters only.
module conv_seq_ctrl #(
   parameter int IMG_W  = conv_pkg::IMG_W,
   parameter int ADDR_W = 12,
   parameter int POOL_W = conv_pkg::POOL_W
) (
   input  logic            clk,
   input  logic            reset,
   conv_seq_ctrl_if.master bus
);
   import conv_pkg::state_t, conv_pkg::S_IDLE, conv_pkg::S_CONV,
          conv_pkg::S_WB0, conv_pkg::S_POOL, conv_pkg::S_WB1, conv_pkg::S_DONE,
          conv_pkg::CSEL_NONE, conv_pkg::CSEL_L0, conv_pkg::CSEL_L1;

   localparam int CW  = $clog2(IMG_W);
   localparam int PW  = $clog2(POOL_W * POOL_W);
   localparam int PCW = CW - 1;
   localparam logic [CW-1:0] LAST_RC = CW'(IMG_W - 1);
   localparam logic [PW-1:0] LAST_P  = PW'(POOL_W * POOL_W - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [3:0]        tap_q, tap_d;
   logic [PW-1:0]     pool_q, pool_d;
   logic [1:0]        sub_q, sub_d;
   logic [ADDR_W-1:0] win_addr;
   logic              win_pad;

   conv_win_addr #(
      .ROW_W (CW),
      .AW    (ADDR_W)
   ) u_win (
      .row     (row_q),
      .col     (col_q),
      .tap     (tap_q),
      .iaddr   (win_addr),
      .mac_pad (win_pad)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         tap_q   <= '0;
         pool_q  <= '0;
         sub_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         tap_q   <= tap_d;
         pool_q  <= pool_d;
         sub_q   <= sub_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      tap_d   = tap_q;
      pool_d  = pool_q;
      sub_d   = sub_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ready) begin
               state_d = S_CONV;
               row_d   = '0;
               col_d   = '0;
               tap_d   = '0;
               pool_d  = '0;
               sub_d   = '0;
            end
         end
         S_CONV: begin
            if (tap_q == 4'd8) begin
               state_d = S_WB0;
               tap_d   = '0;
            end else begin
               tap_d = tap_q + 4'd1;
            end
         end
         S_WB0: begin
            // Row-major raster: column wraps naturally, row steps on wrap.
            col_d = col_q + 1'b1;
            if (col_q == LAST_RC) begin
               row_d = row_q + 1'b1;
            end
            if ((row_q == LAST_RC) && (col_q == LAST_RC)) begin
               state_d = S_POOL;
               pool_d  = '0;
               sub_d   = '0;
            end else begin
               state_d = S_CONV;
            end
         end
         S_POOL: begin
            sub_d = sub_q + 2'd1;
            if (sub_q == 2'd3) begin
               state_d = S_WB1;
            end
         end
         S_WB1: begin
            if (pool_q == LAST_P) begin
               state_d = S_DONE;
            end else begin
               pool_d  = pool_q + 1'b1;
               state_d = S_POOL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = 1'b0;
      bus.iaddr    = '0;
      bus.tap_idx  = '0;
      bus.mac_clr  = 1'b0;
      bus.mac_en   = 1'b0;
      bus.mac_pad  = 1'b0;
      bus.pool_ld  = 1'b0;
      bus.pool_en  = 1'b0;
      bus.wb_sel   = 1'b0;
      bus.cwr      = 1'b0;
      bus.caddr_wr = '0;
      bus.crd      = 1'b0;
      bus.caddr_rd = '0;
      bus.csel     = CSEL_NONE;
      case (state_q)
         S_CONV: begin
            bus.busy    = 1'b1;
            bus.iaddr   = win_addr;
            bus.mac_pad = win_pad;
            bus.mac_en  = 1'b1;
            bus.mac_clr = (tap_q == 4'd0);
            bus.tap_idx = tap_q;
         end
         S_WB0: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = CSEL_L0;
            bus.caddr_wr = ADDR_W'({row_q, col_q});
         end
         S_POOL: begin
            // {pr, j/2, pc, j%2} == (2*pr + j/2)*IMG_W + 2*pc + j%2
            bus.busy     = 1'b1;
            bus.crd      = 1'b1;
            bus.csel     = CSEL_L0;
            bus.caddr_rd = ADDR_W'({pool_q[PW-1:PCW], sub_q[1],
                                    pool_q[PCW-1:0], sub_q[0]});
            bus.pool_ld  = (sub_q == 2'd0);
            bus.pool_en  = (sub_q != 2'd0);
         end
         S_WB1: begin
            bus.busy     = 1'b1;
            bus.cwr      = 1'b1;
            bus.csel     = CSEL_L1;
            bus.wb_sel   = 1'b1;
            bus.caddr_wr = ADDR_W'(pool_q);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl. The stimulus process pushes the
// expected output vector of every monitored cycle into exp_q (job traces are
// generated from the raster/pool rules with plain loops); the monitor pops one
// entry per cycle at the falling edge and compares, and also checks busy
// length and per-address write counts at the end of each completed job.
module tb_conv_seq_ctrl;

   localparam int IMG      = 64;
   localparam int AW       = 12;
   localparam int PWID     = 32;
   localparam int JOB_CYC  = 46080;
   localparam int ABORT_AT = 1004;  // pixel 100, tap 4

   typedef struct packed {
      logic          busy;
      logic [AW-1:0] iaddr;
      logic [3:0]    tap;
      logic          mac_clr;
      logic          mac_en;
      logic          mac_pad;
      logic          pool_ld;
      logic          pool_en;
      logic          wb_sel;
      logic          cwr;
      logic [AW-1:0] caddr_wr;
      logic          crd;
      logic [AW-1:0] caddr_rd;
      logic [2:0]    csel;
   } out_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   conv_seq_ctrl_if #(.ADDR_W(AW)) bus_if ();

   conv_seq_ctrl #(
      .IMG_W  (IMG),
      .ADDR_W (AW),
      .POOL_W (PWID)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   out_t exp_q[$];
   int   total      = 0;
   int   bad        = 0;
   bit   mon_on     = 1'b0;
   bit   abort_flag = 1'b0;
   int   job_checks = 0;
   int   run_len    = 0;
   bit   prev_busy  = 1'b0;
   int   cyc        = 0;
   int   l0_cnt [4096];
   int   l1_cnt [1024];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_idle();
      out_t o;
      o = '0;
      exp_q.push_back(o);
   endtask

   task automatic rand_ready();
      bus_if.ready = 1'($urandom_range(0, 1));
   endtask

   // Expected trace of one job: raster conv, then pool, then the DONE cycle.
   task automatic build_job(input int limit);
      int   n;
      out_t o;
      n = 0;
      for (int r = 0; r < IMG; r++) begin
         for (int c = 0; c < IMG; c++) begin
            for (int k = 0; k < 9; k++) begin
               int rr;
               int cc;
               rr        = r + k / 3 - 1;
               cc        = c + k % 3 - 1;
               o         = '0;
               o.busy    = 1'b1;
               o.tap     = 4'(k);
               o.mac_en  = 1'b1;
               o.mac_clr = (k == 0);
               o.mac_pad = (rr < 0) || (rr >= IMG) || (cc < 0) || (cc >= IMG);
               if (!o.mac_pad) o.iaddr = AW'(rr * IMG + cc);
               if (n < limit) exp_q.push_back(o);
               n++;
            end
            o          = '0;
            o.busy     = 1'b1;
            o.cwr      = 1'b1;
            o.csel     = 3'b001;
            o.caddr_wr = AW'(r * IMG + c);
            if (n < limit) exp_q.push_back(o);
            n++;
         end
      end
      for (int p = 0; p < PWID * PWID; p++) begin
         for (int j = 0; j < 4; j++) begin
            o          = '0;
            o.busy     = 1'b1;
            o.crd      = 1'b1;
            o.csel     = 3'b001;
            o.caddr_rd = AW'((2 * (p / PWID) + j / 2) * IMG + 2 * (p % PWID) + j % 2);
            o.pool_ld  = (j == 0);
            o.pool_en  = (j != 0);
            if (n < limit) exp_q.push_back(o);
            n++;
         end
         o          = '0;
         o.busy     = 1'b1;
         o.cwr      = 1'b1;
         o.csel     = 3'b011;
         o.wb_sel   = 1'b1;
         o.caddr_wr = AW'(p);
         if (n < limit) exp_q.push_back(o);
         n++;
      end
      o = '0;
      if (n < limit) exp_q.push_back(o);
   endtask

   // Monitor / checker
   always @(negedge clk) begin
      out_t a;
      out_t e;
      int   once0;
      int   once1;
      if (mon_on) begin
         a.busy     = bus_if.busy;
         a.iaddr    = bus_if.iaddr;
         a.tap      = bus_if.tap_idx;
         a.mac_clr  = bus_if.mac_clr;
         a.mac_en   = bus_if.mac_en;
         a.mac_pad  = bus_if.mac_pad;
         a.pool_ld  = bus_if.pool_ld;
         a.pool_en  = bus_if.pool_en;
         a.wb_sel   = bus_if.wb_sel;
         a.cwr      = bus_if.cwr;
         a.caddr_wr = bus_if.caddr_wr;
         a.crd      = bus_if.crd;
         a.caddr_rd = bus_if.caddr_rd;
         a.csel     = bus_if.csel;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_underflow cyc=%0d got=%h required=<queued entry>", cyc, a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cyc=%0d got=%h required=%h (busy %b/%b iaddr %0d/%0d tap %0d/%0d pad %b/%b cwr %b/%b waddr %0d/%0d crd %b/%b raddr %0d/%0d csel %b/%b)",
                        cyc, a, e, a.busy, e.busy, a.iaddr, e.iaddr, a.tap, e.tap,
                        a.mac_pad, e.mac_pad, a.cwr, e.cwr, a.caddr_wr, e.caddr_wr,
                        a.crd, e.crd, a.caddr_rd, e.caddr_rd, a.csel, e.csel);
            end
         end

         if (a.busy && !prev_busy) begin
            run_len = 0;
            foreach (l0_cnt[i]) l0_cnt[i] = 0;
            foreach (l1_cnt[i]) l1_cnt[i] = 0;
         end
         if (a.busy) begin
            run_len++;
            if (a.cwr && a.csel == 3'b001) l0_cnt[a.caddr_wr]++;
            if (a.cwr && a.csel == 3'b011 && a.caddr_wr < AW'(1024)) l1_cnt[a.caddr_wr[9:0]]++;
         end
         if (!a.busy && prev_busy && !abort_flag) begin
            once0 = 0;
            once1 = 0;
            foreach (l0_cnt[i]) if (l0_cnt[i] == 1) once0++;
            foreach (l1_cnt[i]) if (l1_cnt[i] == 1) once1++;
            total++;
            if (run_len != JOB_CYC) begin
               bad++;
               $display("FAIL busy_length got=%0d required=%0d", run_len, JOB_CYC);
            end
            total++;
            if (once0 != 4096) begin
               bad++;
               $display("FAIL l0_writes_once got=%0d required=4096", once0);
            end
            total++;
            if (once1 != 1024) begin
               bad++;
               $display("FAIL l1_writes_once got=%0d required=1024", once1);
            end
            job_checks++;
         end
         prev_busy = a.busy;
         cyc++;
      end
   end

   // Stimulus
   initial begin
      bus_if.ready = 1'b0;
      reset        = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      push_idle();
      mon_on = 1'b1;
      repeat (5) begin
         step();
         push_idle();
      end

      // Job aborted by reset during pixel 100
      step();
      bus_if.ready = 1'b1;
      push_idle();
      step();
      rand_ready();
      build_job(ABORT_AT + 1);
      repeat (ABORT_AT) begin
         step();
         rand_ready();
      end
      reset      = 1'b1;
      abort_flag = 1'b1;
      step();
      reset        = 1'b0;
      bus_if.ready = 1'b0;
      push_idle();
      repeat ($urandom_range(3, 8)) begin
         step();
         push_idle();
      end
      abort_flag = 1'b0;

      // Full job with ready noise throughout (must be ignored)
      step();
      bus_if.ready = 1'b1;
      push_idle();
      step();
      rand_ready();
      build_job(JOB_CYC + 1);
      repeat (JOB_CYC) begin
         step();
         rand_ready();
      end
      repeat (4) begin
         step();
         bus_if.ready = 1'b0;
         push_idle();
      end
      @(negedge clk);
      #1;
      mon_on = 1'b0;

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expected got=%0d required=0", exp_q.size());
      end
      total++;
      if (job_checks != 1) begin
         bad++;
         $display("FAIL completed_jobs got=%0d required=1", job_checks);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
